uart_boot_ctrl: RTL

//  Sequences program download from the UART byte receiver into CPU instruction memory.

---
 rtl/uart_boot_pkg.sv | 34 +++
 rtl/boot_timeout_ctr.sv | 35 +++
 rtl/uart_boot_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_boot_pkg.sv
// ============================================================================
// Module   : uart_boot_pkg
// Brief    : Shared state encoding, error codes and defaults for the UART boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_boot_pkg;

    localparam int         c_ST_W       = 3;
    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_WAIT_SYNC = 3'd1;
    localparam logic [2:0] c_S_GET_LEN  = 3'd2;
    localparam logic [2:0] c_S_GET_DATA = 3'd3;
    localparam logic [2:0] c_S_GET_CSUM = 3'd4;
    localparam logic [2:0] c_S_DONE     = 3'd5;
    localparam logic [2:0] c_S_ERROR    = 3'd6;

    localparam logic [1:0] c_ERR_NONE   = 2'b00;
    localparam logic [1:0] c_ERR_FE     = 2'b01;
    localparam logic [1:0] c_ERR_CSUM   = 2'b10;
    localparam logic [1:0] c_ERR_LEN_TO = 2'b11;

    localparam logic [7:0] c_SYNC_BYTE_DEF = 8'hA5;

    // Packet-parsing states, i.e. where a download is in progress.
    function automatic logic is_busy_st(input logic [c_ST_W-1:0] s);
        return (s == c_S_WAIT_SYNC) || (s == c_S_GET_LEN) ||
               (s == c_S_GET_DATA)  || (s == c_S_GET_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/boot_timeout_ctr.sv
// ============================================================================
// Module   : boot_timeout_ctr
// Brief    : Saturating inter-byte idle counter; flags expiry after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_timeout_ctr #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int             c_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_W-1:0] c_LIMIT = c_W'(TIMEOUT);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/uart_boot_ctrl.sv
// ============================================================================
// Module   : uart_boot_ctrl
// Brief    : Parses SYNC/LEN/payload/checksum frames from UART RX into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_boot_ctrl
    import uart_boot_pkg::*;
#(
    parameter int         ADDR_W    = 5,
    parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = 50000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_fe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int         c_CW      = ADDR_W + 1;
    localparam logic [8:0] c_MAX_LEN = 9'(1 << ADDR_W);

    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [1:0]        r_err, w_err_nxt;
    logic [c_CW-1:0]   r_cnt, r_len, w_cnt_inc;
    logic [7:0]        r_sum;
    logic              w_expire, w_to_en;
    logic              w_we, w_busy, w_hold, w_done;
    logic              r_mem_we, r_cpu_hold, r_busy, r_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_to_en   = (r_state == c_S_GET_LEN) || (r_state == c_S_GET_DATA) ||
                       (r_state == c_S_GET_CSUM);

    boot_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (Clk),
        .rst      (Rst),
        .i_clr    (rx_valid || !w_to_en),
        .i_en     (w_to_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= c_S_IDLE;
            r_err   <= c_ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A frame-error byte anywhere in the packet beats its own content and the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_ERROR: begin
                if (start) begin
                    w_state_nxt = c_S_WAIT_SYNC;
                    w_err_nxt   = c_ERR_NONE;
                end
            end
            c_S_WAIT_SYNC: begin
                if (rx_valid && rx_fe) begin
                    w_state_nxt = c_S_ERROR;
                    w_err_nxt   = c_ERR_FE;
                end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_nxt = c_S_GET_LEN;
                end
            end
            c_S_GET_LEN, c_S_GET_DATA, c_S_GET_CSUM: begin
                if (rx_valid && rx_fe) begin
                    w_state_nxt = c_S_ERROR;
                    w_err_nxt   = c_ERR_FE;
                end else if (rx_valid) begin
                    if (r_state == c_S_GET_LEN) begin
                        if ((rx_data == 8'd0) || ({1'b0, rx_data} > c_MAX_LEN)) begin
                            w_state_nxt = c_S_ERROR;
                            w_err_nxt   = c_ERR_LEN_TO;
                        end else begin
                            w_state_nxt = c_S_GET_DATA;
                        end
                    end else if (r_state == c_S_GET_DATA) begin
                        if (w_cnt_inc == r_len) begin
                            w_state_nxt = c_S_GET_CSUM;
                        end
                    end else if (rx_data == r_sum) begin
                        w_state_nxt = c_S_DONE;
                    end else begin
                        w_state_nxt = c_S_ERROR;
                        w_err_nxt   = c_ERR_CSUM;
                    end
                end else if (w_expire) begin
                    w_state_nxt = c_S_ERROR;
                    w_err_nxt   = c_ERR_LEN_TO;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_err_nxt   = c_ERR_NONE;
            end
        endcase
    end

    // The CPU is only released from a clean DONE; IDLE leaves it running untouched.
    always_comb begin
        w_we   = (r_state == c_S_GET_DATA) && rx_valid && !rx_fe;
        w_busy = is_busy_st(w_state_nxt);
        w_done = (w_state_nxt == c_S_DONE);
        w_hold = (w_state_nxt != c_S_IDLE) && (w_state_nxt != c_S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sum       <= '0;
        end else begin
            r_mem_we   <= w_we;
            r_cpu_hold <= w_hold;
            r_busy     <= w_busy;
            r_done     <= w_done;
            if ((r_state == c_S_GET_LEN) && rx_valid && !rx_fe) begin
                r_len <= c_CW'(rx_data);
                r_cnt <= '0;
                r_sum <= '0;
            end
            if (w_we) begin
                r_mem_addr  <= r_cnt[ADDR_W-1:0];
                r_mem_wdata <= rx_data;
                r_cnt       <= w_cnt_inc;
                r_sum       <= r_sum + rx_data;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire
